// File: rtl/adc_capture_pkg.sv
// =====================================================================
// adc_capture_pkg: shared state encoding and PIO bit positions for the ADC capture block
// Revision 1.0
// =====================================================================
`default_nettype none

package adc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_SWTRIG = 1;
    localparam int CTRL_EXTEN  = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_DONE = 15;
    localparam int STAT_BUSY = 14;

    function automatic logic is_busy(state_e s);
        return (s == ST_ARMED) || (s == ST_WAIT_TRIG) || (s == ST_CAPTURE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sample_ram.sv
// =====================================================================
// adc_sample_ram: simple dual-port sample buffer, one write port, one registered read port
// Revision 1.0
// =====================================================================
`default_nettype none

module adc_sample_ram #(
    parameter int DEPTH = 1024,
    parameter int ADC_W = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [ADC_W-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [ADC_W-1:0]         rd_data_o
);

    logic [ADC_W-1:0] mem_q [DEPTH];
    logic [ADC_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/adc_capture_sequencer.sv
// =====================================================================
// adc_capture_sequencer: PIO-controlled trigger capture of an ADC stream with pre-trigger window
// Revision 1.0
// =====================================================================
`default_nettype none

module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADC_W   = 14,
    parameter int PRETRIG = 128
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             trig_in,
    input  logic [7:0]       adc_control,
    input  logic [15:0]      samplenum,
    output logic [15:0]      wavesample,
    output logic             capture_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRETRIG_CNT = CW'(PRETRIG);
    localparam logic [CW-1:0] CAPLEN_CNT  = CW'(DEPTH - PRETRIG);
    localparam logic [AW-1:0] PRETRIG_PTR = AW'(PRETRIG);

    // Edge detectors
    logic arm_prev_q, sw_prev_q, abort_prev_q, trig_prev_q;
    logic arm_edge_q, sw_edge_q, abort_edge_q, ext_edge_q;

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  start_ptr_q, start_ptr_d;
    logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
    logic           trig_latch_q, trig_latch_d;
    logic           capture_done_q, capture_done_d;
    logic           wr_en;
    logic           trig_evt;
    logic [CW-1:0]  fill_inc;

    logic [AW-1:0]    rd_addr_q;
    logic             done_q, busy_q;
    logic [ADC_W-1:0] rd_data;
    logic             unused_bits;

    assign unused_bits = ^{adc_control[7:4], samplenum[15:AW]};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            arm_prev_q   <= 1'b0;
            sw_prev_q    <= 1'b0;
            abort_prev_q <= 1'b0;
            trig_prev_q  <= 1'b0;
            arm_edge_q   <= 1'b0;
            sw_edge_q    <= 1'b0;
            abort_edge_q <= 1'b0;
            ext_edge_q   <= 1'b0;
        end else begin
            arm_prev_q   <= adc_control[CTRL_ARM];
            sw_prev_q    <= adc_control[CTRL_SWTRIG];
            abort_prev_q <= adc_control[CTRL_ABORT];
            trig_prev_q  <= trig_in;
            arm_edge_q   <= adc_control[CTRL_ARM]    & ~arm_prev_q;
            sw_edge_q    <= adc_control[CTRL_SWTRIG] & ~sw_prev_q;
            abort_edge_q <= adc_control[CTRL_ABORT]  & ~abort_prev_q;
            ext_edge_q   <= trig_in & ~trig_prev_q;
        end
    end

    // A trigger pulse pairs with the sample strobed in the same cycle; a pulse
    // landing on an idle strobe cycle is held until the next valid sample.
    assign trig_evt = sw_edge_q | (ext_edge_q & adc_control[CTRL_EXTEN]) | trig_latch_q;
    assign fill_inc = fill_cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        trig_latch_d = 1'b0;
        wr_en        = 1'b0;

        if (abort_edge_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_edge_q) begin
                        state_d    = ST_ARMED;
                        wr_ptr_d   = '0;
                        fill_cnt_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (adc_valid) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AW'(1);
                        fill_cnt_d = fill_inc;
                        if (fill_inc >= PRETRIG_CNT) begin
                            state_d = ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (adc_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (trig_evt) begin
                            start_ptr_d = wr_ptr_q - PRETRIG_PTR;
                            fill_cnt_d  = CW'(1);
                            state_d     = (CW'(1) >= CAPLEN_CNT) ? ST_DONE : ST_CAPTURE;
                        end
                    end else begin
                        trig_latch_d = trig_evt;
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AW'(1);
                        fill_cnt_d = fill_inc;
                        if (fill_inc >= CAPLEN_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        capture_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            start_ptr_q    <= '0;
            fill_cnt_q     <= '0;
            trig_latch_q   <= 1'b0;
            capture_done_q <= 1'b0;
            rd_addr_q      <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            start_ptr_q    <= start_ptr_d;
            fill_cnt_q     <= fill_cnt_d;
            trig_latch_q   <= trig_latch_d;
            capture_done_q <= capture_done_d;
            rd_addr_q      <= start_ptr_q + samplenum[AW-1:0];
            done_q         <= (state_q == ST_DONE);
            busy_q         <= is_busy(state_q);
        end
    end

    adc_sample_ram #(
        .DEPTH (DEPTH),
        .ADC_W (ADC_W)
    ) u_ram (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (adc_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        wavesample              = '0;
        wavesample[ADC_W-1:0]   = rd_data;
        wavesample[STAT_DONE]   = done_q;
        wavesample[STAT_BUSY]   = busy_q;
    end

    assign capture_done = capture_done_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_sequencer.sv
// =====================================================================
// tb_adc_capture_sequencer: directed capture scenarios checked against a behavioural buffer model
// Revision 1.0
// =====================================================================
`default_nettype none

module tb_adc_capture_sequencer;

    localparam int DEPTH   = 1024;
    localparam int ADC_W   = 14;
    localparam int PRETRIG = 128;

    localparam int P_IDLE    = 0;
    localparam int P_ARMED   = 1;
    localparam int P_WAIT    = 2;
    localparam int P_CAPTURE = 3;
    localparam int P_DONE    = 4;

    logic             clk = 1'b0;
    logic             reset_reset_n = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             adc_valid = 1'b0;
    logic             trig_in = 1'b0;
    logic [7:0]       adc_control = 8'h00;
    logic [15:0]      samplenum = 16'd0;
    logic [15:0]      wavesample;
    logic             capture_done;

    always #5 clk = ~clk;

    adc_capture_sequencer #(
        .DEPTH   (DEPTH),
        .ADC_W   (ADC_W),
        .PRETRIG (PRETRIG)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_reset_n),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .trig_in       (trig_in),
        .adc_control   (adc_control),
        .samplenum     (samplenum),
        .wavesample    (wavesample),
        .capture_done  (capture_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, m_wp, m_cnt, m_start, m_addr;
    bit          m_latch;
    bit          ev_arm, ev_sw, ev_ext, ev_abort;
    bit          pv_arm, pv_sw, pv_abort, pv_trig;
    int          m_ram [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] exp_ws;
    bit          exp_known, exp_cd, m_init;

    function automatic void store();
        m_ram[m_wp]   = int'(adc_data);
        m_known[m_wp] = 1'b1;
        m_wp          = (m_wp + 1) % DEPTH;
    endfunction

    function automatic bit busy_of(input int p);
        return (p == P_ARMED) || (p == P_WAIT) || (p == P_CAPTURE);
    endfunction

    always @(posedge clk) begin : model
        int old_phase;
        bit trig;
        if (!reset_reset_n) begin
            m_phase = P_IDLE; m_wp = 0; m_cnt = 0; m_start = 0; m_addr = 0; m_latch = 0;
            ev_arm = 0; ev_sw = 0; ev_ext = 0; ev_abort = 0;
            pv_arm = 0; pv_sw = 0; pv_abort = 0; pv_trig = 0;
            exp_ws = 16'h0000; exp_known = 1; exp_cd = 0; m_init = 1;
        end else begin
            // what the readback word must show after this edge
            exp_ws        = 16'(m_ram[m_addr] & 16'h3FFF);
            exp_ws[15]    = (m_phase == P_DONE);
            exp_ws[14]    = busy_of(m_phase);
            exp_known     = m_known[m_addr];
            m_addr        = (m_start + int'(samplenum)) % DEPTH;
            old_phase     = m_phase;
            trig          = ev_sw || (ev_ext && adc_control[2]) || m_latch;
            m_latch       = 0;
            if (ev_abort) begin
                m_phase = P_IDLE;
            end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
                if (ev_arm) begin m_phase = P_ARMED; m_wp = 0; m_cnt = 0; end
            end else if (m_phase == P_ARMED) begin
                if (adc_valid) begin
                    store(); m_cnt++;
                    if (m_cnt >= PRETRIG) m_phase = P_WAIT;
                end
            end else if (m_phase == P_WAIT) begin
                if (adc_valid) begin
                    if (trig) begin
                        m_start = (m_wp - PRETRIG + DEPTH) % DEPTH;
                        m_cnt   = 1;
                        m_phase = (m_cnt >= DEPTH - PRETRIG) ? P_DONE : P_CAPTURE;
                    end
                    store();
                end else begin
                    m_latch = trig;
                end
            end else if (m_phase == P_CAPTURE) begin
                if (adc_valid) begin
                    store(); m_cnt++;
                    if (m_cnt >= DEPTH - PRETRIG) m_phase = P_DONE;
                end
            end
            exp_cd   = (m_phase == P_DONE) && (old_phase != P_DONE);
            ev_arm   = adc_control[0] && !pv_arm;
            ev_sw    = adc_control[1] && !pv_sw;
            ev_abort = adc_control[3] && !pv_abort;
            ev_ext   = trig_in && !pv_trig;
            pv_arm   = adc_control[0];
            pv_sw    = adc_control[1];
            pv_abort = adc_control[3];
            pv_trig  = trig_in;
        end
    end

    always @(negedge clk) begin : compare
        if (m_init) begin
            chk("capture_done", int'(capture_done), int'(exp_cd));
            chk("status_bits", int'(wavesample[15:14]), int'(exp_ws[15:14]));
            if (exp_known) chk("sample_word", int'(wavesample[13:0]), int'(exp_ws[13:0]));
        end
    end

    // ---------------- stimulus ----------------
    int ramp = 0;
    int last_sent = -1;
    int done_at = -1;
    int cd_count = 0;

    task automatic step(input bit v);
        adc_valid = v;
        adc_data  = v ? ADC_W'(ramp) : '0;
        @(posedge clk);
        #1;
        if (v) begin last_sent = ramp; ramp++; end
        if (capture_done) begin cd_count++; done_at = last_sent; end
    endtask

    task automatic feed_to(input int target);
        while (ramp < target) step(1'b1);
    endtask

    task automatic arm();
        adc_control[0] = 1'b0; step(1'b0);
        adc_control[0] = 1'b1; step(1'b0); step(1'b0);
        ramp = 0;
    endtask

    task automatic run_until_done(input int bound);
        int start_cnt = cd_count;
        int i = 0;
        while (cd_count == start_cnt && i < bound) begin step(1'b1); i++; end
        if (cd_count == start_cnt) chk("done_timeout", 0, 1);
    endtask

    task automatic rd(input int n, output int v);
        samplenum = 16'(n);
        step(1'b0); step(1'b0);
        v = int'(wavesample[13:0]);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : stim
        int v;
        // reset values with samplenum=5
        samplenum = 16'd5;
        repeat (4) step(1'b0);
        chk("reset_wavesample", int'(wavesample), 0);
        chk("reset_capture_done", int'(capture_done), 0);
        reset_reset_n = 1'b1;
        repeat (3) step(1'b0);
        chk("idle_status", int'(wavesample[15:14]), 0);
        chk("idle_no_done", cd_count, 0);

        // soft trigger at ramp value 500
        arm();
        feed_to(499);
        adc_control[1] = 1'b1; step(1'b1); adc_control[1] = 1'b0;
        run_until_done(2000);
        chk("t2_done_at", done_at, 1395);
        chk("t2_pulses", cd_count, 1);
        rd(0, v);    chk("t2_rd0", v, 372);
        rd(128, v);  chk("t2_rd128", v, 500);
        rd(1023, v); chk("t2_rd1023", v, 1395);
        chk("t2_status_done", int'(wavesample[15:14]), 2);

        // trigger during ARMED is discarded; second trigger at 700
        arm();
        feed_to(50);
        adc_control[1] = 1'b1; step(1'b1); step(1'b1); adc_control[1] = 1'b0;
        feed_to(699);
        adc_control[1] = 1'b1; step(1'b1); adc_control[1] = 1'b0;
        run_until_done(2000);
        chk("t3_done_at", done_at, 1595);
        chk("t3_pulses", cd_count, 2);
        rd(128, v);  chk("t3_rd128", v, 700);
        rd(0, v);    chk("t3_rd0", v, 572);

        // external trigger gated by enable bit
        arm();
        adc_control[2] = 1'b0;
        feed_to(299);
        trig_in = 1'b1; step(1'b1); step(1'b1); trig_in = 1'b0;
        feed_to(1499);
        chk("t4_no_capture", cd_count, 2);
        chk("t4_busy", int'(wavesample[14]), 1);
        adc_control[2] = 1'b1;
        trig_in = 1'b1; step(1'b1); trig_in = 1'b0;
        run_until_done(2000);
        adc_control[2] = 1'b0;
        chk("t4_done_at", done_at, 2395);
        rd(128, v);  chk("t4_rd128", v, 1500);
        rd(0, v);    chk("t4_rd0", v, 1372);

        // abort mid-capture, then simultaneous abort+arm
        arm();
        feed_to(199);
        adc_control[1] = 1'b1; step(1'b1); adc_control[1] = 1'b0;
        feed_to(400);
        adc_control[3] = 1'b1;
        repeat (3) step(1'b1);
        chk("t5_abort_status", int'(wavesample[15:14]), 0);
        adc_control = 8'h00; repeat (2) step(1'b0);
        adc_control = 8'h09; repeat (4) step(1'b1);
        chk("t5_abort_arm_idle", int'(wavesample[15:14]), 0);
        chk("t5_no_done", cd_count, 3);
        adc_control = 8'h00; repeat (2) step(1'b0);

        // trigger on a non-valid cycle, capture window wraps
        arm();
        feed_to(1073);
        adc_control[1] = 1'b1; step(1'b1); step(1'b0); adc_control[1] = 1'b0;
        run_until_done(2000);
        chk("t6_done_at", done_at, 1969);
        rd(0, v);    chk("t6_rd0", v, 946);
        rd(128, v);  chk("t6_rd128", v, 1074);
        rd(1023, v); chk("t6_rd1023", v, 1969);

        // reset during capture
        arm();
        feed_to(600);
        adc_control[1] = 1'b1; step(1'b1); adc_control[1] = 1'b0;
        feed_to(700);
        adc_control = 8'h00;
        reset_reset_n = 1'b0; step(1'b1);
        reset_reset_n = 1'b1; step(1'b1); step(1'b1);
        chk("t7_reset_status", int'(wavesample[15:14]), 0);
        chk("t7_no_done", cd_count, 4);
        repeat (3) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences ADC waveform capture for the Qsys system: decodes the 8-bit `adc_control` PIO byte written by the Nios, fills a circular sample buffer from the ADC stream, and freezes it on a trigger with a fixed pre-trigger window. It serves the frozen waveform back over the `samplenum` / `wavesample` PIO pair, so software can read samples one by one and forward them over Ethernet. Sits in the top level between the ADC data pins and the Qsys PIO exports.

## Interface
- `DEPTH`, 1024: buffer length in samples; power of two, 16..16384.
- `ADC_W`, 14: ADC sample width; ≤14.
- `PRETRIG`, 128: samples kept before the trigger sample; < `DEPTH`.

- `clk_clk` in 1: single clock for all logic, including the ADC data strobe.
- `reset_reset_n` in 1: synchronous, active-low reset.
- `adc_data` in `ADC_W`: ADC sample.
- `adc_valid` in 1: sample strobe, one cycle per sample.
- `trig_in` in 1: external trigger, already synchronous to `clk_clk`.
- `adc_control` in 8: PIO byte.
  - bit0 arm.
  - bit1 soft trigger.
  - bit2 external trigger enable.
  - bit3 abort.
  - bits7:4 reserved, ignored.
- `samplenum` in 16: readback index relative to the window start; only the low log2(`DEPTH`) bits are used.
- `wavesample` out 16: readback word.
  - [15] done.
  - [14] busy (ARMED or WAIT_TRIG or CAPTURE).
  - [13:0] sample, zero-extended.
- `capture_done` out 1: one-cycle pulse on entry to DONE.

## Operation
- Rising-edge detect on bits 0, 1 and 3 of `adc_control`, and on `trig_in`. Edge registers reset to 0. PIO levels are never acted on directly.
- FSM states and transitions:
  - **IDLE**: arm edge → ARMED. Clear `wr_ptr` and `fill_cnt`.
  - **ARMED**: write each valid sample at `wr_ptr` and increment it. After `PRETRIG` samples → WAIT_TRIG. Triggers in this state are discarded, not latched.
  - **WAIT_TRIG**: write samples continuously (wrapping). A trigger is a soft-trigger edge, or a `trig_in` edge while bit2=1.
    - Trigger coinciding with `adc_valid`: that sample is the trigger sample.
    - Trigger without `adc_valid`: latched, and the next valid sample is the trigger sample.
    - On the trigger sample: `start_ptr` ← `wr_ptr` − `PRETRIG` mod `DEPTH`, then → CAPTURE.
  - **CAPTURE**: continue writing. When `DEPTH` − `PRETRIG` samples have been written, counting the trigger sample → DONE.
  - **DONE**: no writes; buffer frozen. Arm edge → ARMED (re-arm clears pointers).
- Abort edge in any state → IDLE next cycle. Buffer contents are retained, done=0.
- Simultaneous abort and arm: abort wins. Arm edge in ARMED, WAIT_TRIG or CAPTURE is ignored.
- Readback address = `start_ptr` + `samplenum` mod `DEPTH`. `samplenum` 0 is the oldest pre-trigger sample; `samplenum` = `PRETRIG` is the trigger sample.
- Reads are allowed in any state. Outside DONE they return raw RAM content at that address.
- Counters are log2(`DEPTH`)+1 bits wide. Pointer arithmetic is modulo `DEPTH`, with natural wrap.

## Timing
- Reset values:
  - state IDLE.
  - `wavesample` 0.
  - `capture_done` 0.
  - `start_ptr`, `wr_ptr`, `fill_cnt` 0.
  - trigger latch 0.
- Control edge → state change: 2 cycles after the PIO bit changes (1 cycle for the edge register, 1 for the state register).
- Sample written to RAM 1 cycle after `adc_valid`.
- Readback latency: `samplenum` change → `wavesample` valid 2 cycles later (registered address, synchronous RAM read). Status bits [15:14] follow state with 1 cycle latency.
- `adc_valid` may be asserted every cycle; no samples are dropped in ARMED, WAIT_TRIG or CAPTURE.
- Reset asserted mid-capture returns to IDLE on the next edge. RAM is not cleared.

## Structure
- Shared package `adc_capture_pkg`:
  - state enum.
  - control bit index constants (ARM=0, SWTRIG=1, EXTEN=2, ABORT=3).
  - status bit indices (DONE=15, BUSY=14).
- Sub-module `adc_sample_ram`: simple dual-port RAM, one write port and one registered read port. Parameterised by `DEPTH` and `ADC_W`; infers block RAM.

## Test plan
- Reset, then `adc_control`=0x00 and `samplenum`=5 → `wavesample`=0x0000, `capture_done` never pulses.
- Ramp data (sample n = n), arm, soft trigger at ramp value 500, `DEPTH`=1024, `PRETRIG`=128 → done after sample 1395. `samplenum` 0 reads 372, 128 reads 500, 1023 reads 1395. `wavesample`[15]=1 and one `capture_done` pulse.
- Soft trigger issued during ARMED (fewer than 128 samples written) → ignored. Second trigger after fill → trigger sample equals the ramp value at the second trigger.
- `trig_in` edge with bit2=0 → no capture. Same edge with bit2=1 → CAPTURE, trigger sample = ramp value at the edge.
- Abort during CAPTURE → busy=0, done=0 within 2 cycles. Re-arm with abort and arm bits rising together (0x09) → stays IDLE.
- `adc_valid` every cycle with the trigger on a cycle where `adc_valid`=0 → the trigger sample is the next valid sample. Capture wraps: trigger at `wr_ptr`=50 gives `start_ptr`=946.
